// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state encoding,
// BCD digit constants and a helper for sizing the binary result.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BCD_NIBBLE_W  = 4;
    localparam int BCD_MAX_DIGIT = 9;

    // Smallest binary width that can hold any value below 10**digits.
    function automatic int min_bin_w(input int digits);
        longint unsigned lim;
        int              w;
        lim = 64'd1;
        w   = 0;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 64'd10;
        end
        while ((64'd1 << w) < lim) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// One Horner step of the conversion: acc*10 + digit, plus a flag raised
// when the digit is not a valid decimal value. Purely combinational.
module bcd_mac_step
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0]        i_acc,
    input  logic [BCD_NIBBLE_W-1:0] i_digit,
    output logic [BIN_W-1:0]        o_acc,
    output logic                    o_bad
);

    localparam int EXT_W = BIN_W + BCD_NIBBLE_W;

    logic [EXT_W-1:0] w_ext;

    // Widen so the x8 + x2 sum cannot wrap before the final truncation;
    // an invalid digit is folded in with its raw value.
    always_comb begin
        w_ext = {{BCD_NIBBLE_W{1'b0}}, i_acc};
        o_acc = BIN_W'((w_ext << 3) + (w_ext << 1) + EXT_W'(i_digit));
        o_bad = (i_digit > BCD_NIBBLE_W'(BCD_MAX_DIGIT));
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative multi-digit BCD-to-binary converter. One digit per clock,
// most significant digit first, with a START/DONE handshake and an error
// flag for any nibble above 9.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic [4*DIGITS-1:0]      BCD_IN,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [BIN_W-1:0]         BIN_OUT,
    output logic                     ERR
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SH_W  = BCD_NIBBLE_W * DIGITS;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic [BIN_W-1:0]        r_bin;
    logic                    r_err;
    logic [BIN_W-1:0]        r_acc;
    logic [SH_W-1:0]         r_shift;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err_acc;

    logic [BIN_W-1:0]        w_acc_next;
    logic                    w_bad;
    logic [BCD_NIBBLE_W-1:0] w_digit;

    assign w_digit = r_shift[SH_W-1 -: BCD_NIBBLE_W];

    bcd_mac_step #(
        .BIN_W (BIN_W)
    ) u_mac (
        .i_acc   (r_acc),
        .i_digit (w_digit),
        .o_acc   (w_acc_next),
        .o_bad   (w_bad)
    );

    // Control FSM with shift register, digit counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bin     <= '0;
            r_err     <= 1'b0;
            r_acc     <= '0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts START exactly like IDLE, giving back-to-back runs.
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        r_shift   <= BCD_IN;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_err_acc <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CONV;
                    end else begin
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    r_acc     <= w_acc_next;
                    r_shift   <= r_shift << BCD_NIBBLE_W;
                    r_cnt     <= r_cnt + 1'b1;
                    r_err_acc <= r_err_acc | w_bad;
                    if (r_cnt == CNT_W'(DIGITS - 1)) begin
                        r_bin   <= w_acc_next;
                        r_err   <= r_err_acc | w_bad;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign BIN_OUT = r_bin;
    assign ERR     = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed corners, handshake cases,
// reset abort and randomized words against a positional-sum reference.
module tb_bcd_to_bin;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic                 CLK;
    logic                 RESET;
    logic                 START;
    logic [4*DIGITS-1:0]  BCD_IN;
    logic                 BUSY;
    logic                 DONE;
    logic [BIN_W-1:0]     BIN_OUT;
    logic                 ERR;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    bit mon_on = 0;

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .BCD_IN  (BCD_IN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .BIN_OUT (BIN_OUT),
        .ERR     (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: value = sum of digit_i * 10^i, reduced modulo 2^BIN_W.
    function automatic int ref_val(input logic [4*DIGITS-1:0] bcd);
        longint v;
        longint p;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v = v + longint'(bcd[4*i +: 4]) * p;
            p = p * 10;
        end
        return int'(v % (longint'(1) << BIN_W));
    endfunction

    function automatic int ref_err(input logic [4*DIGITS-1:0] bcd);
        int e;
        e = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) e = 1;
        end
        return e;
    endfunction

    // DONE and BUSY must never be high together; also count DONE pulses.
    always @(negedge CLK) begin
        if (mon_on) begin
            chk("done_busy_excl", {31'd0, DONE & BUSY}, 32'd0);
            if (DONE) done_seen++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Run one conversion, check latency, result, flag and DONE width.
    task automatic convert(input logic [4*DIGITS-1:0] bcd, input string tag);
        int n;
        BCD_IN = bcd;
        START  = 1'b1;
        tick();
        START  = 1'b0;
        BCD_IN = 16'($urandom);
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
        n = 0;
        while (!DONE && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, DIGITS);
        chk({tag, "_bin"}, {18'd0, BIN_OUT}, ref_val(bcd));
        chk({tag, "_err"}, {31'd0, ERR}, ref_err(bcd));
        tick();
        chk({tag, "_done_pulse"}, {31'd0, DONE}, 32'd0);
        chk({tag, "_hold"}, {18'd0, BIN_OUT}, ref_val(bcd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int cyc_list[$];
        logic [4*DIGITS-1:0] w;

        RESET  = 1'b1;
        START  = 1'b0;
        BCD_IN = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_bin", {18'd0, BIN_OUT}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        RESET  = 1'b0;
        mon_on = 1'b1;
        tick();

        convert(16'h1234, "c1234");
        chk("c1234_val", {18'd0, BIN_OUT}, 32'd1234);
        convert(16'h9999, "c9999");
        chk("c9999_val", {18'd0, BIN_OUT}, 32'd9999);
        convert(16'h0000, "c0000");
        convert(16'h0001, "c0001");
        convert(16'h12A4, "c12A4");
        chk("c12A4_val", {18'd0, BIN_OUT}, 32'd1304);
        chk("c12A4_errflag", {31'd0, ERR}, 32'd1);
        convert(16'h0042, "c0042");
        chk("c0042_val", {18'd0, BIN_OUT}, 32'd42);
        chk("c0042_errflag", {31'd0, ERR}, 32'd0);

        // START while busy is ignored; exactly one DONE with the first word.
        d0 = done_seen;
        BCD_IN = 16'h0321;
        START  = 1'b1;
        tick();
        START  = 1'b0;
        tick();
        BCD_IN = 16'h0999;
        START  = 1'b1;
        tick();
        START  = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("busy_start_dones", done_seen - d0, 32'd1);
        chk("busy_start_bin", {18'd0, BIN_OUT}, 32'd321);

        // START held: back-to-back conversions every DIGITS+1 cycles.
        BCD_IN = 16'h0777;
        START  = 1'b1;
        tick();
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (DONE) begin
                cyc_list.push_back(c);
                chk("b2b_bin", {18'd0, BIN_OUT}, 32'd777);
            end
            if (c == 19) START = 1'b0;
        end
        chk("b2b_count", cyc_list.size(), 32'd4);
        if (cyc_list.size() == 4) begin
            chk("b2b_first", cyc_list[0], DIGITS);
            for (int i = 1; i < 4; i++) begin
                chk("b2b_period", cyc_list[i] - cyc_list[i-1], DIGITS + 1);
            end
        end
        for (int i = 0; i < 3; i++) tick();
        chk("b2b_idle", {31'd0, BUSY}, 32'd0);

        // Reset mid-conversion aborts without a DONE pulse.
        d0 = done_seen;
        BCD_IN = 16'h5678;
        START  = 1'b1;
        tick();
        START  = 1'b0;
        tick();
        RESET  = 1'b1;
        tick();
        RESET  = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("abort_dones", done_seen - d0, 32'd0);
        chk("abort_bin", {18'd0, BIN_OUT}, 32'd0);
        chk("abort_err", {31'd0, ERR}, 32'd0);
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        convert(16'h5678, "c5678");
        chk("c5678_val", {18'd0, BIN_OUT}, 32'd5678);

        // Randomized words: half valid BCD, half raw 16-bit values.
        for (int k = 0; k < 40; k++) begin
            if (k[0]) begin
                w = 16'($urandom);
            end else begin
                for (int i = 0; i < DIGITS; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            convert(w, "rnd");
        end

        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
